id_ex_stage: RTL and testbench

- ID/EX pipeline boundary of the pipelined RV32I core. Latches the decoded control bundle, operands and immediate from the ID stage into the EX stage.
- Contains load-use hazard detection and inserts bubbles on load-use stalls and on redirects resolved in EX.
- Drives pipeline stall/flush requests upstream to the PC and IF/ID register.
- Keeps saturating stall/flush event counters for performance debug.

---
 rtl/pcpu_pkg.sv | 66 ++++++
 rtl/load_use_detect.sv | 29 ++
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_pkg.sv
// Shared encodings and the decoded control bundle passed from the ID stage to the EX stage
// of the pipelined RV32I core.
package pcpu_pkg;

    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_MEM = 2'b01,
        WD_PC  = 2'b10
    } wd_sel_e;

    typedef enum logic [2:0] {
        NPC_PLUS4  = 3'b000,
        NPC_BRANCH = 3'b001,
        NPC_JUMP   = 3'b010,
        NPC_JALR   = 3'b100
    } npc_op_e;

    typedef enum logic [4:0] {
        ALU_NOP  = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_SLL  = 5'd3,
        ALU_SLT  = 5'd4,
        ALU_SLTU = 5'd5,
        ALU_XOR  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_OR   = 5'd9,
        ALU_AND  = 5'd10,
        ALU_LUI  = 5'd11,
        ALU_BEQ  = 5'd12,
        ALU_BNE  = 5'd13,
        ALU_BLT  = 5'd14,
        ALU_BGE  = 5'd15,
        ALU_BLTU = 5'd16,
        ALU_BGEU = 5'd17
    } alu_op_e;

    typedef enum logic [2:0] {
        DM_W  = 3'b000,
        DM_H  = 3'b001,
        DM_HU = 3'b010,
        DM_B  = 3'b011,
        DM_BU = 3'b100
    } dm_type_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic [4:0] alu_op;
        logic [2:0] npc_op;
        logic [1:0] wd_sel;
        logic [2:0] dm_type;
    } ctrl_t;

    // A bubble has no side effects and falls through to PC+4.
    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c        = '0;
        c.npc_op = NPC_PLUS4;
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load sitting in EX and the
// instruction presented by ID.
import pcpu_pkg::*;

module load_use_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [1:0] ex_wd_sel,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    output logic       load_use
);

    logic ex_ld;
    logic rs1_hit;
    logic rs2_hit;

    // jalr also raises mem_read in the decoder; only a real load writes back from memory.
    assign ex_ld   = ex_valid & ex_mem_read & (ex_wd_sel == WD_MEM);
    assign rs1_hit = id_rs1_used & (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_used & (id_rs2 == ex_rd);

    assign load_use = ex_ld & id_valid & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, redirect flush, upstream
// stall/flush requests and saturating performance counters.
import pcpu_pkg::*;

module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_reg_write,
    input  logic            id_mem_write,
    input  logic            id_mem_read,
    input  logic            id_alu_src,
    input  logic [4:0]      id_alu_op,
    input  logic [2:0]      id_npc_op,
    input  logic [1:0]      id_wd_sel,
    input  logic [2:0]      id_dm_type,
    input  logic            ex_redirect,
    input  logic            ex_hold,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic            ex_reg_write,
    output logic            ex_mem_write,
    output logic            ex_mem_read,
    output logic            ex_alu_src,
    output logic [4:0]      ex_alu_op,
    output logic [2:0]      ex_npc_op,
    output logic [1:0]      ex_wd_sel,
    output logic [2:0]      ex_dm_type,
    output logic            stall_o,
    output logic            flush_ifid_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  load_use;
    logic  do_bubble;
    logic  stall_evt;
    logic  flush_evt;

    assign id_ctrl = '{
        reg_write: id_reg_write,
        mem_write: id_mem_write,
        mem_read:  id_mem_read,
        alu_src:   id_alu_src,
        alu_op:    id_alu_op,
        npc_op:    id_npc_op,
        wd_sel:    id_wd_sel,
        dm_type:   id_dm_type
    };

    load_use_detect u_load_use_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_wd_sel   (ex_ctrl.wd_sel),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .load_use    (load_use)
    );

    // Upstream contract: while stall_o is high, PC and IF/ID hold and re-present the same
    // instruction next cycle; flush_ifid_o clears IF/ID. ex_hold freezes EX outright, and a
    // redirect must stay asserted across a hold so it is acted on exactly once when released.
    assign flush_ifid_o = ex_redirect & ~ex_hold;
    assign stall_o      = ex_hold | (load_use & ~ex_redirect);

    assign do_bubble = ex_redirect | load_use;
    assign stall_evt = load_use & ~ex_redirect & ~ex_hold;
    assign flush_evt = ex_redirect & ~ex_hold;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else if (!ex_hold) begin
            if (do_bubble) begin
                ex_valid <= 1'b0;
                ex_pc    <= '0;
                ex_rs1   <= '0;
                ex_rs2   <= '0;
                ex_rd    <= '0;
                ex_rd1   <= '0;
                ex_rd2   <= '0;
                ex_imm   <= '0;
                ex_ctrl  <= bubble_ctrl();
            end else begin
                // Loaded even when id_valid is low; EX gates side effects on ex_valid.
                ex_valid <= id_valid;
                ex_pc    <= id_pc;
                ex_rs1   <= id_rs1;
                ex_rs2   <= id_rs2;
                ex_rd    <= id_rd;
                ex_rd1   <= id_rd1;
                ex_rd2   <= id_rd2;
                ex_imm   <= id_imm;
                ex_ctrl  <= id_ctrl;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign ex_reg_write = ex_ctrl.reg_write;
    assign ex_mem_write = ex_ctrl.mem_write;
    assign ex_mem_read  = ex_ctrl.mem_read;
    assign ex_alu_src   = ex_ctrl.alu_src;
    assign ex_alu_op    = ex_ctrl.alu_op;
    assign ex_npc_op    = ex_ctrl.npc_op;
    assign ex_wd_sel    = ex_ctrl.wd_sel;
    assign ex_dm_type   = ex_ctrl.dm_type;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus randomized traffic
// against a cycle-level reference model of the ID/EX boundary.
module tb_id_ex_stage;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic            clk;
    logic            rstn;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_rs1_used, id_rs2_used;
    logic [XLEN-1:0] id_rd1, id_rd2, id_imm;
    logic            id_reg_write, id_mem_write, id_mem_read, id_alu_src;
    logic [4:0]      id_alu_op;
    logic [2:0]      id_npc_op;
    logic [1:0]      id_wd_sel;
    logic [2:0]      id_dm_type;
    logic            ex_redirect, ex_hold;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0] ex_rd1, ex_rd2, ex_imm;
    logic            ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_src;
    logic [4:0]      ex_alu_op;
    logic [2:0]      ex_npc_op;
    logic [1:0]      ex_wd_sel;
    logic [2:0]      ex_dm_type;
    logic            stall_o, flush_ifid_o;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_mem_read(id_mem_read),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_npc_op(id_npc_op),
        .id_wd_sel(id_wd_sel), .id_dm_type(id_dm_type),
        .ex_redirect(ex_redirect), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_npc_op(ex_npc_op),
        .ex_wd_sel(ex_wd_sel), .ex_dm_type(ex_dm_type),
        .stall_o(stall_o), .flush_ifid_o(flush_ifid_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the EX stage should hold, plus event counts.
    typedef struct {
        logic        valid;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd, alu_op;
        logic        reg_write, mem_write, mem_read, alu_src;
        logic [2:0]  npc_op, dm_type;
        logic [1:0]  wd_sel;
    } ex_model_t;

    ex_model_t m;
    int        m_stalls;
    int        m_flushes;

    function automatic ex_model_t bubble();
        ex_model_t b;
        b = '{default: '0};
        return b;
    endfunction

    function automatic ex_model_t from_id();
        ex_model_t e;
        e.valid = id_valid;   e.pc = id_pc;         e.rd1 = id_rd1;       e.rd2 = id_rd2;
        e.imm = id_imm;       e.rs1 = id_rs1;       e.rs2 = id_rs2;       e.rd = id_rd;
        e.alu_op = id_alu_op; e.reg_write = id_reg_write; e.mem_write = id_mem_write;
        e.mem_read = id_mem_read; e.alu_src = id_alu_src; e.npc_op = id_npc_op;
        e.dm_type = id_dm_type; e.wd_sel = id_wd_sel;
        return e;
    endfunction

    function automatic bit model_load_use();
        bit reads_rd;
        reads_rd = (id_rs1_used && id_rs1 == m.rd) || (id_rs2_used && id_rs2 == m.rd);
        return m.valid && m.mem_read && (m.wd_sel == 2'b01) && id_valid && (m.rd != 0) && reads_rd;
    endfunction

    // Scoreboard compare
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_ex();
        check("ex_valid", 32'(ex_valid), 32'(m.valid));
        check("ex_pc", ex_pc, m.pc);
        check("ex_rs1", 32'(ex_rs1), 32'(m.rs1));
        check("ex_rs2", 32'(ex_rs2), 32'(m.rs2));
        check("ex_rd", 32'(ex_rd), 32'(m.rd));
        check("ex_rd1", ex_rd1, m.rd1);
        check("ex_rd2", ex_rd2, m.rd2);
        check("ex_imm", ex_imm, m.imm);
        check("ex_reg_write", 32'(ex_reg_write), 32'(m.reg_write));
        check("ex_mem_write", 32'(ex_mem_write), 32'(m.mem_write));
        check("ex_mem_read", 32'(ex_mem_read), 32'(m.mem_read));
        check("ex_alu_src", 32'(ex_alu_src), 32'(m.alu_src));
        check("ex_alu_op", 32'(ex_alu_op), 32'(m.alu_op));
        check("ex_npc_op", 32'(ex_npc_op), 32'(m.npc_op));
        check("ex_wd_sel", 32'(ex_wd_sel), 32'(m.wd_sel));
        check("ex_dm_type", 32'(ex_dm_type), 32'(m.dm_type));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
    endtask

    // One clock: check upstream requests, advance the model at the edge, check EX.
    task automatic step();
        bit lu;
        #1;
        lu = model_load_use();
        check("stall_o", 32'(stall_o), 32'(ex_hold || (lu && !ex_redirect)));
        check("flush_ifid_o", 32'(flush_ifid_o), 32'(ex_redirect && !ex_hold));
        @(posedge clk);
        if (!ex_hold) begin
            if (ex_redirect) begin
                m = bubble();
                if (m_flushes < CNT_MAX) m_flushes++;
            end else if (lu) begin
                m = bubble();
                if (m_stalls < CNT_MAX) m_stalls++;
            end else begin
                m = from_id();
            end
        end
        #1;
        check_ex();
        @(negedge clk);
    endtask

    // Drivers
    task automatic rand_id();
        id_valid = 1'($urandom_range(0, 7) != 0);
        id_pc = $urandom;  id_rd1 = $urandom;  id_rd2 = $urandom;  id_imm = $urandom;
        id_rs1 = 5'($urandom_range(0, 3));
        id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
        id_rs1_used = 1'($urandom);  id_rs2_used = 1'($urandom);
        id_reg_write = 1'($urandom); id_mem_write = 1'($urandom);
        id_mem_read = 1'($urandom);  id_alu_src = 1'($urandom);
        id_alu_op = 5'($urandom);    id_npc_op = 3'($urandom);
        id_wd_sel = 2'($urandom);    id_dm_type = 3'($urandom);
    endtask

    task automatic set_inst(input bit v, input int rd, input int rs1, input bit r1u,
                            input int rs2, input bit r2u, input bit mrd, input int wds);
        rand_id();
        id_valid = v;  id_rd = 5'(rd);
        id_rs1 = 5'(rs1);  id_rs1_used = r1u;
        id_rs2 = 5'(rs2);  id_rs2_used = r2u;
        id_mem_read = mrd; id_wd_sel = 2'(wds);
        id_reg_write = 1'b1; id_mem_write = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; ex_hold = 1'b0; ex_redirect = 1'b0;
        rand_id();
        m = bubble(); m_stalls = 0; m_flushes = 0;
        #2;
        check_ex();
        check("stall_o_rst", 32'(stall_o), 32'(0));
        check("flush_rst", 32'(flush_ifid_o), 32'(0));
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;

        // Load-use stall: lw x5 then add x6,x5,x1
        set_inst(1, 5, 2, 1, 0, 0, 1, 1); step();
        set_inst(1, 6, 5, 1, 1, 1, 0, 0); step();
        check("tp_stall_cnt", 32'(stall_cnt), 32'(1));
        step();
        check("tp_add_loaded", 32'(ex_rd), 32'(6));

        // jalr rd=5 reading-back x5: no stall
        set_inst(1, 5, 1, 1, 0, 0, 1, 2); id_npc_op = 3'b100; step();
        set_inst(1, 7, 5, 1, 0, 0, 0, 0); step();
        check("tp_jalr_no_stall", 32'(ex_rd), 32'(7));

        // lw x0 then reader of x0: no stall
        set_inst(1, 0, 1, 1, 0, 0, 1, 1); step();
        set_inst(1, 8, 0, 1, 0, 1, 0, 0); step();

        // Redirect together with load-use
        set_inst(1, 5, 2, 1, 0, 0, 1, 1); step();
        set_inst(1, 6, 0, 0, 5, 1, 0, 0); ex_redirect = 1'b1; step();
        ex_redirect = 1'b0;

        // Hold with a pending redirect, then release
        set_inst(1, 9, 1, 0, 2, 0, 0, 0); step();
        ex_hold = 1'b1; ex_redirect = 1'b1;
        repeat (3) begin rand_id(); step(); end
        ex_hold = 1'b0; step();
        ex_redirect = 1'b0;

        // Counter saturation: lw x5,0(x5) repeatedly stalls on itself
        set_inst(1, 5, 5, 1, 0, 0, 1, 1);
        repeat (40) step();
        check("tp_stall_sat", 32'(stall_cnt), 32'(CNT_MAX));

        // Random traffic
        repeat (2000) begin
            rand_id();
            ex_hold = 1'($urandom_range(0, 7) == 0);
            ex_redirect = 1'($urandom_range(0, 5) == 0);
            step();
        end

        // Asynchronous reset mid-stall
        ex_hold = 1'b0; ex_redirect = 1'b0;
        set_inst(1, 5, 2, 1, 0, 0, 1, 1); step();
        set_inst(1, 6, 5, 1, 0, 0, 0, 0);
        #2;
        rstn = 1'b0;
        m = bubble(); m_stalls = 0; m_flushes = 0;
        #1;
        check_ex();
        check("stall_o_async_rst", 32'(stall_o), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        step();
        check("post_rst_load", 32'(ex_rd), 32'(6));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
